// File: rtl/sad_min_sel_if.sv
// sad_min_sel_if: bundle between a SAD source and the candidate selector.
// The source (master) drives start/sad/sad_vld; the selector (slave)
// drives the result, status pulses and a debug view of its FSM state.
interface sad_min_sel_if #(
    parameter int SAD_BITS = 16,
    parameter int SR       = 4
);
    localparam int MVW = $clog2(2 * SR) + 1;

    // Handshake: no backpressure. start and sad_vld are one-cycle qualifiers
    // sampled on the rising clock edge; sad is meaningful only when sad_vld
    // is high. best_vld and cnt_err are one-cycle pulses. best_* are also
    // held until the next window completes, so a slow consumer may read
    // them later.
    logic                       start;
    logic [SAD_BITS-1:0]        sad;
    logic                       sad_vld;
    logic                       busy;
    logic [SAD_BITS-1:0]        best_sad;
    logic signed [MVW-1:0]      best_mvx;
    logic signed [MVW-1:0]      best_mvy;
    logic                       best_vld;
    logic                       cnt_err;
    logic                       dbg_state;   // 0 = IDLE, 1 = SCAN

    modport master (
        output start, sad, sad_vld,
        input  busy, best_sad, best_mvx, best_mvy, best_vld, cnt_err, dbg_state
    );

    modport slave (
        input  start, sad, sad_vld,
        output busy, best_sad, best_mvx, best_mvy, best_vld, cnt_err, dbg_state
    );
endinterface

// File: rtl/sad_min_sel.sv
// sad_min_sel: tracks the minimum SAD over one 2*SR x 2*SR search window
// (raster order) and reports the winning raw SAD and its motion vector.
// Optional feature macro: SAD_MIN_BIAS_EN -- when defined, the zero MV
// candidate gets a saturating ZMV_BIAS credit before comparison.
module sad_min_sel #(
    parameter int SAD_BITS = 16,
    parameter int SR       = 4,
    parameter int ZMV_BIAS = 64
) (
    input  logic         clk,
    input  logic         rst,
    sad_min_sel_if.slave bus
);
    localparam int CW  = $clog2(2 * SR);
    localparam int MVW = CW + 1;
    localparam logic [CW-1:0] LAST = CW'(2 * SR - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic [CW-1:0]       r_col;
    logic [CW-1:0]       r_row;
    logic [CW-1:0]       r_best_col;
    logic [CW-1:0]       r_best_row;
    logic [SAD_BITS-1:0] r_min_eff;
    logic [SAD_BITS-1:0] r_min_raw;
    logic [SAD_BITS-1:0] r_best_sad;
    logic [MVW-1:0]      r_best_mvx;
    logic [MVW-1:0]      r_best_mvy;
    logic                r_best_vld;
    logic                r_cnt_err;

    logic                w_accept;
    logic [CW-1:0]       w_col;
    logic [CW-1:0]       w_row;
    logic [SAD_BITS-1:0] w_base_eff;
    logic [SAD_BITS-1:0] w_base_raw;
    logic [CW-1:0]       w_base_bcol;
    logic [CW-1:0]       w_base_brow;
    logic [SAD_BITS-1:0] w_eff;
    logic                w_take;
    logic [SAD_BITS-1:0] w_new_eff;
    logic [SAD_BITS-1:0] w_new_raw;
    logic [CW-1:0]       w_new_bcol;
    logic [CW-1:0]       w_new_brow;
    logic                w_last;
    logic [MVW-1:0]      w_mvx;
    logic [MVW-1:0]      w_mvy;

`ifdef SAD_MIN_BIAS_EN
    localparam int CTR_I = SR;
    localparam logic [CW-1:0]       CTR  = CW'(CTR_I);
    localparam logic [SAD_BITS-1:0] BIAS = SAD_BITS'(ZMV_BIAS);
    logic w_is_zmv;

    // Saturating credit for the zero motion vector candidate only.
    always_comb begin
        w_is_zmv = (w_col == CTR) && (w_row == CTR);
        w_eff    = bus.sad;
        if (w_is_zmv) begin
            w_eff = (bus.sad > BIAS) ? (bus.sad - BIAS) : '0;
        end
    end
`else
    // Without the bias every candidate competes on its raw SAD.
    always_comb begin
        w_eff = bus.sad;
    end
`endif

    // Candidate position and running best, as seen by this cycle's sad;
    // a same-cycle start makes this sad candidate 0 of a fresh window.
    always_comb begin
        w_accept    = bus.sad_vld && (bus.start || (r_state == SCAN));
        w_col       = bus.start ? '0 : r_col;
        w_row       = bus.start ? '0 : r_row;
        w_base_eff  = bus.start ? '1 : r_min_eff;
        w_base_raw  = bus.start ? '1 : r_min_raw;
        w_base_bcol = bus.start ? '0 : r_best_col;
        w_base_brow = bus.start ? '0 : r_best_row;
        // Strictly-less keeps the earliest candidate on ties.
        w_take      = (w_eff < w_base_eff);
        w_new_eff   = w_take ? w_eff   : w_base_eff;
        w_new_raw   = w_take ? bus.sad : w_base_raw;
        w_new_bcol  = w_take ? w_col   : w_base_bcol;
        w_new_brow  = w_take ? w_row   : w_base_brow;
        w_last      = (w_col == LAST) && (w_row == LAST);
        // Column/row index minus SR gives the signed MV component.
        w_mvx       = {1'b0, w_new_bcol} - MVW'(SR);
        w_mvy       = {1'b0, w_new_brow} - MVW'(SR);
    end

    // FSM, candidate counters, running minimum and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_best_col <= '0;
            r_best_row <= '0;
            r_min_eff  <= '1;
            r_min_raw  <= '1;
            r_best_sad <= '0;
            r_best_mvx <= '0;
            r_best_mvy <= '0;
            r_best_vld <= 1'b0;
            r_cnt_err  <= 1'b0;
        end else begin
            r_best_vld <= 1'b0;
            r_cnt_err  <= bus.sad_vld && !bus.start && (r_state == IDLE);
            if (bus.start) begin
                // Open (or reopen) a window; any partial window is dropped.
                r_state    <= SCAN;
                r_busy     <= 1'b1;
                r_col      <= '0;
                r_row      <= '0;
                r_min_eff  <= '1;
                r_min_raw  <= '1;
                r_best_col <= '0;
                r_best_row <= '0;
            end
            if (w_accept) begin
                r_min_eff  <= w_new_eff;
                r_min_raw  <= w_new_raw;
                r_best_col <= w_new_bcol;
                r_best_row <= w_new_brow;
                if (w_col == LAST) begin
                    r_col <= '0;
                    r_row <= w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
                if (w_last) begin
                    r_best_sad <= w_new_raw;
                    r_best_mvx <= w_mvx;
                    r_best_mvy <= w_mvy;
                    r_best_vld <= 1'b1;
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                end
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.best_sad  = r_best_sad;
    assign bus.best_mvx  = r_best_mvx;
    assign bus.best_mvy  = r_best_mvy;
    assign bus.best_vld  = r_best_vld;
    assign bus.cnt_err   = r_cnt_err;
    assign bus.dbg_state = (r_state == SCAN);
endmodule

// File: tb/tb_sad_min_sel.sv
// tb_sad_min_sel: directed tests for sad_min_sel with SR=4 (64 candidates).
module tb_sad_min_sel;
    localparam int SAD_BITS = 16;
    localparam int SR       = 4;
    localparam int N        = (2 * SR) * (2 * SR);

    logic clk;
    logic rst;

    sad_min_sel_if #(.SAD_BITS(SAD_BITS), .SR(SR)) bus ();

    sad_min_sel #(.SAD_BITS(SAD_BITS), .SR(SR), .ZMV_BIAS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [15:0] win [N];
    logic [23:0] got_q [$];
    logic [23:0] exp_q [$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: capture every result pulse
    always @(negedge clk) begin
        if (bus.best_vld === 1'b1)
            got_q.push_back({bus.best_sad, bus.best_mvx, bus.best_mvy});
    end

    function automatic logic [23:0] res(input int s, input int x, input int y);
        return {16'(s), 4'(x), 4'(y)};
    endfunction

    function automatic logic [23:0] cur_res();
        return {bus.best_sad, bus.best_mvx, bus.best_mvy};
    endfunction

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) win[i] = 16'(v);
    endtask

    // driver: present win[first..last] (start on the first one if asked),
    // optional random gaps between candidates, busy checked when asked
    task automatic feed(input int first, input int last, input int gap_max,
                        input bit with_start, input bit chk_busy);
        for (int k = first; k <= last; k++) begin
            int g;
            g = (gap_max > 0 && k > first) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                if (chk_busy) begin
                    cmp_cnt++;
                    if (bus.busy !== 1'b1) begin
                        err_cnt++;
                        $display("FAIL busy_gap k=%0d: got %b want 1", k, bus.busy);
                    end
                end
                bus.start   = 1'b0;
                bus.sad_vld = 1'b0;
            end
            @(negedge clk);
            if (chk_busy && k > first) begin
                cmp_cnt++;
                if (bus.busy !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL busy_scan k=%0d: got %b want 1", k, bus.busy);
                end
            end
            bus.start   = with_start && (k == first);
            bus.sad     = win[k];
            bus.sad_vld = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.sad_vld = 1'b0;
        end
    endtask

    // compare captured results against exp_q, then empty both
    task automatic score(input string name);
        cmp_cnt++;
        if (got_q.size() !== exp_q.size()) begin
            err_cnt++;
            $display("FAIL %s_count: got %0d results want %0d", name, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [23:0] g;
            logic [23:0] e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            cmp_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL %s_result: got %h want %h", name, g, e);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.sad     = '0;
        bus.sad_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp_cnt++;
        if ({bus.busy, bus.best_sad, bus.best_mvx, bus.best_mvy, bus.best_vld, bus.cnt_err, bus.dbg_state} !== 27'd0) begin
            err_cnt++;
            $display("FAIL reset_values: got busy=%b sad=%h mv=%h,%h vld=%b err=%b st=%b want all 0",
                     bus.busy, bus.best_sad, bus.best_mvx, bus.best_mvy, bus.best_vld, bus.cnt_err, bus.dbg_state);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_descending();
        for (int k = 0; k < N; k++) win[k] = 16'(1000 - k);
        feed(0, N - 1, 0, 1'b1, 1'b1);
        @(negedge clk);
        bus.sad_vld = 1'b0;
        cmp_cnt++;
        if (bus.best_vld !== 1'b1 || cur_res() !== res(937, 3, 3)) begin
            err_cnt++;
            $display("FAIL desc_latency: got vld=%b res=%h want vld=1 res=%h", bus.best_vld, cur_res(), res(937, 3, 3));
        end
        cmp_cnt++;
        if (bus.busy !== 1'b0 || bus.dbg_state !== 1'b0) begin
            err_cnt++;
            $display("FAIL desc_busy_fall: got busy=%b st=%b want 0 0", bus.busy, bus.dbg_state);
        end
        @(negedge clk);
        cmp_cnt++;
        if (bus.best_vld !== 1'b0 || cur_res() !== res(937, 3, 3)) begin
            err_cnt++;
            $display("FAIL desc_pulse_hold: got vld=%b res=%h want vld=0 res=%h", bus.best_vld, cur_res(), res(937, 3, 3));
        end
        exp_q.push_back(res(937, 3, 3));
        score("desc");
    endtask

    task automatic test_tie();
        fill(16'h0100);
        win[9]  = 16'h0010;
        win[20] = 16'h0010;
        feed(0, N - 1, 0, 1'b1, 1'b0);
        idle(3);
        exp_q.push_back(res(16'h0010, -3, -3));
        score("tie");
    endtask

    task automatic test_gapped();
        for (int k = 0; k < N; k++) win[k] = 16'(200 + k);
        feed(0, N - 1, 3, 1'b1, 1'b1);
        idle(4);
        exp_q.push_back(res(200, -4, -4));
        score("gapped");
    endtask

    task automatic test_restart();
        fill(5);
        feed(0, 29, 0, 1'b1, 1'b0);
        idle(1);
        fill(900);
        win[50] = 16'd7;
        feed(0, N - 1, 0, 1'b1, 1'b1);
        idle(3);
        exp_q.push_back(res(7, -2, 2));
        score("restart");
        // sad_vld while idle: error pulse, result untouched
        @(negedge clk);
        bus.sad     = 16'd1;
        bus.sad_vld = 1'b1;
        @(negedge clk);
        bus.sad_vld = 1'b0;
        cmp_cnt++;
        if (bus.cnt_err !== 1'b1) begin
            err_cnt++;
            $display("FAIL cnt_err_pulse: got %b want 1", bus.cnt_err);
        end
        @(negedge clk);
        cmp_cnt++;
        if (bus.cnt_err !== 1'b0 || bus.busy !== 1'b0 || cur_res() !== res(7, -2, 2)) begin
            err_cnt++;
            $display("FAIL cnt_err_hold: got err=%b busy=%b res=%h want 0 0 %h", bus.cnt_err, bus.busy, cur_res(), res(7, -2, 2));
        end
        idle(1);
        score("idle_vld");
    endtask

    task automatic test_bias();
        fill(16'hFFFF);
        win[36] = 16'd500;
        win[0]  = 16'd450;
        feed(0, N - 1, 0, 1'b1, 1'b0);
        idle(3);
`ifdef SAD_MIN_BIAS_EN
        exp_q.push_back(res(500, 0, 0));
`else
        exp_q.push_back(res(450, -4, -4));
`endif
        score("bias");
    endtask

    task automatic test_all_ones();
        fill(16'hFFFF);
        feed(0, N - 1, 0, 1'b1, 1'b0);
        idle(3);
`ifdef SAD_MIN_BIAS_EN
        exp_q.push_back(res(16'hFFFF, 0, 0));
`else
        exp_q.push_back(res(16'hFFFF, -4, -4));
`endif
        score("all_ones");
    endtask

    task automatic test_back_to_back();
        // second start lands in the cycle best_vld of the first is high
        fill(300);
        win[63] = 16'd3;
        feed(0, N - 1, 0, 1'b1, 1'b0);
        fill(400);
        win[27] = 16'd4;
        feed(0, N - 1, 0, 1'b1, 1'b1);
        idle(3);
        exp_q.push_back(res(3, 3, 3));
        exp_q.push_back(res(4, -1, -1));
        score("b2b");
    endtask

    task automatic test_reset_mid();
        fill(2);
        feed(0, 39, 0, 1'b1, 1'b0);
        @(negedge clk);
        bus.sad_vld = 1'b0;
        rst = 1'b1;
        #1;
        cmp_cnt++;
        if ({bus.busy, bus.best_sad, bus.best_mvx, bus.best_mvy, bus.best_vld, bus.cnt_err, bus.dbg_state} !== 27'd0) begin
            err_cnt++;
            $display("FAIL rst_mid_async: got busy=%b sad=%h mv=%h,%h vld=%b st=%b want all 0",
                     bus.busy, bus.best_sad, bus.best_mvx, bus.best_mvy, bus.best_vld, bus.dbg_state);
        end
        idle(2);
        rst = 1'b0;
        idle(4);
        score("rst_mid_quiet");
        fill(600);
        win[12] = 16'd6;
        feed(0, N - 1, 0, 1'b1, 1'b0);
        idle(3);
        exp_q.push_back(res(6, 0, -3));
        score("rst_mid_next");
    endtask

    initial begin
        test_reset();
        test_descending();
        test_tie();
        test_gapped();
        test_restart();
        test_bias();
        test_all_ones();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
